// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types and constants for the paddle mover
// Purpose: play-cycle state encoding, default coordinate width, visible
//          screen limits and a counter-width helper.
// Ports:   none (package)
package paddle_pkg;

  localparam int COORD_W_DEF = 16;

  // Visible area of the 640x480 VGA mode the game runs in.
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLIMB = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Bits needed for a frame counter that must hold either load value.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/paddle_frame_timer.sv
// rtl/paddle_frame_timer.sv - loadable per-frame down-counter
// Purpose: counts frames for the RUN and HOLD phases of the play cycle.
// Ports:   clk, rst_n (async, active-low)
//          tick      in  : decrement request (frame_tick gated by state)
//          load      in  : load load_val (wins over tick)
//          load_val  in  W
//          count     out W : current value
//          done      out : the current tick is the last frame of the phase
module paddle_frame_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);

  // The phase ends on the tick that takes the counter to zero, so done
  // is raised while count is 1; a phase loaded with 0 ends immediately.
  assign done = (count <= W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/paddle_mover_p.sv
// rtl/paddle_mover_p.sv - registered single-sprite mover for the VGA game
// Purpose: holds the sprite position, steps it once per frame through the
//          WAIT/RUN/CLIMB/HOLD cycle under button control, and flags scan
//          pixels that fall inside the sprite.
// Config:  PADDLE_PIX_REG_EN - when defined, paddle_pix is registered
//          (1-cycle latency); otherwise it is combinational.
// Ports:   clk, rst_n (async, active-low)
//          frame_tick               in  : one-cycle pulse per frame
//          btn_left/right/launch    in  : debounced levels
//          pix_col, pix_row         in  COORD_W : current scan pixel
//          pos_col, pos_row         out COORD_W : sprite top-left
//          state                    out 2 : WAIT=0 RUN=1 CLIMB=2 HOLD=3
//          lost, scored             out : one-cycle pulses
//          paddle_pix               out : scan pixel inside the sprite
module paddle_mover_p
  import paddle_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int SIZE        = 8,
  parameter int START_COL   = 300,
  parameter int START_ROW   = 399,
  parameter int COL_MIN     = 47,
  parameter int COL_MAX     = 584,
  parameter int ROW_MIN     = 40,
  parameter int STEP        = 1,
  parameter int CLIMB_STEP  = 2,
  parameter int RUN_FRAMES  = 88,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_launch,
  input  logic [COORD_W-1:0] pix_col,
  input  logic [COORD_W-1:0] pix_row,
  output logic [COORD_W-1:0] pos_col,
  output logic [COORD_W-1:0] pos_row,
  output logic [1:0]         state,
  output logic               lost,
  output logic               scored,
  output logic               paddle_pix
);

  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_CLIMB = ST_CLIMB;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  localparam int CNT_W = cnt_width(RUN_FRAMES, HOLD_FRAMES);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   ext_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam coord_t START_C   = coord_t'(START_COL);
  localparam coord_t START_R   = coord_t'(START_ROW);
  localparam coord_t COL_MIN_C = coord_t'(COL_MIN);
  localparam coord_t COL_MAX_C = coord_t'(COL_MAX);
  localparam coord_t ROW_MIN_C = coord_t'(ROW_MIN);
  localparam ext_t   COL_MIN_X = ext_t'(COL_MIN);
  localparam ext_t   COL_MAX_X = ext_t'(COL_MAX);
  localparam ext_t   ROW_MIN_X = ext_t'(ROW_MIN);
  localparam ext_t   STEP_X    = ext_t'(STEP);
  localparam ext_t   CLIMB_X   = ext_t'(CLIMB_STEP);
  localparam ext_t   SIZE_X    = ext_t'(SIZE);

  // ---------------------------------------------------------------
  // Next-position arithmetic, one bit wider so a wrap below zero
  // shows up in the top bit instead of looking like a huge column.
  // ---------------------------------------------------------------
  logic   move_r, move_l;
  ext_t   col_ext, row_ext;
  logic   col_under, loss_min, loss_max, loss, row_hit;
  coord_t col_sat, row_sat;

  assign move_r = btn_right & ~btn_left;
  assign move_l = btn_left & ~btn_right;

  always_comb begin
    col_ext = {1'b0, pos_col};
    if (move_r)      col_ext = {1'b0, pos_col} + STEP_X;
    else if (move_l) col_ext = {1'b0, pos_col} - STEP_X;
  end

  assign col_under = move_l & col_ext[COORD_W];
  assign loss_min  = col_under | (col_ext <= COL_MIN_X);
  assign loss_max  = ~col_under & (col_ext >= COL_MAX_X);
  assign loss      = loss_min | loss_max;

  assign row_ext = {1'b0, pos_row} - CLIMB_X;
  assign row_hit = row_ext[COORD_W] | (row_ext <= ROW_MIN_X);

  assign col_sat = loss_min ? COL_MIN_C :
                   loss_max ? COL_MAX_C : col_ext[COORD_W-1:0];
  assign row_sat = row_hit ? ROW_MIN_C : row_ext[COORD_W-1:0];

  // ---------------------------------------------------------------
  // Frame timer: loaded on launch (RUN length) or on entry to HOLD,
  // counts down only while in RUN or HOLD.
  // ---------------------------------------------------------------
  logic tmr_load, tmr_tick, tmr_done;
  cnt_t tmr_val, tmr_count;
  logic moving;

  assign moving   = (state == S_RUN) || (state == S_CLIMB);
  assign tmr_load = frame_tick &
                    (((state == S_WAIT) & btn_launch) |
                     (moving & (loss | ((state == S_CLIMB) & row_hit))));
  assign tmr_val  = (state == S_WAIT) ? cnt_t'(RUN_FRAMES) : cnt_t'(HOLD_FRAMES);
  assign tmr_tick = frame_tick & ((state == S_RUN) | (state == S_HOLD));

  paddle_frame_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tmr_tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  // ---------------------------------------------------------------
  // Play cycle. Everything except the pulse clear waits for a frame.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_col <= START_C;
      pos_row <= START_R;
      state   <= S_WAIT;
      lost    <= 1'b0;
      scored  <= 1'b0;
    end else begin
      lost   <= 1'b0;
      scored <= 1'b0;
      if (frame_tick) begin
        case (state)
          S_WAIT: begin
            if (btn_launch) state <= S_RUN;
          end
          S_RUN: begin
            pos_col <= col_sat;
            if (loss) begin
              lost  <= 1'b1;
              state <= S_HOLD;
            end else if (tmr_done) begin
              state <= S_CLIMB;
            end
          end
          S_CLIMB: begin
            pos_col <= col_sat;
            pos_row <= row_sat;
            // A loss on the same frame as a score takes precedence.
            if (loss) begin
              lost  <= 1'b1;
              state <= S_HOLD;
            end else if (row_hit) begin
              scored <= 1'b1;
              state  <= S_HOLD;
            end
          end
          default: begin
            if (tmr_done) begin
              state   <= S_WAIT;
              pos_col <= START_C;
              pos_row <= START_R;
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------
  // Sprite coverage, compared in the wide domain so pos+SIZE cannot
  // wrap near the top of the coordinate range.
  // ---------------------------------------------------------------
  logic in_col, in_row, pix_hit;

  assign in_col  = ({1'b0, pix_col} >= {1'b0, pos_col}) &&
                   ({1'b0, pix_col} <  ({1'b0, pos_col} + SIZE_X));
  assign in_row  = ({1'b0, pix_row} >= {1'b0, pos_row}) &&
                   ({1'b0, pix_row} <  ({1'b0, pos_row} + SIZE_X));
  assign pix_hit = in_col & in_row & (state != S_HOLD);

`ifdef PADDLE_PIX_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) paddle_pix <= 1'b0;
    else        paddle_pix <= pix_hit;
  end
`else
  assign paddle_pix = pix_hit;
`endif

endmodule

// File: tb/tb_paddle_mover_p.sv
// tb/tb_paddle_mover_p.sv - directed scoreboard bench for paddle_mover_p
module tb_paddle_mover_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        btn_left, btn_right, btn_launch;
  logic [15:0] pix_col, pix_row;
  logic [15:0] pos_col, pos_row;
  logic [1:0]  state;
  logic        lost, scored, paddle_pix;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string tag;
    int    col;
    int    row;
    int    st;
    int    lst;
    int    scr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  paddle_mover_p dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_launch (btn_launch),
    .pix_col    (pix_col),
    .pix_row    (pix_row),
    .pos_col    (pos_col),
    .pos_row    (pos_row),
    .state      (state),
    .lost       (lost),
    .scored     (scored),
    .paddle_pix (paddle_pix)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int c, input int r,
                          input int s, input int l, input int sc);
    exp_t e;
    e.tag = tag; e.col = c; e.row = r; e.st = s; e.lst = l; e.scr = sc;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "_col"},    int'(pos_col), e.col);
    chk({e.tag, "_row"},    int'(pos_row), e.row);
    chk({e.tag, "_state"},  int'(state),   e.st);
    chk({e.tag, "_lost"},   int'(lost),    e.lst);
    chk({e.tag, "_scored"}, int'(scored),  e.scr);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  task automatic launch();
    btn_launch = 1'b1;
    ticks(1);
    btn_launch = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_launch = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pix_probe(input int c, input int r, input int exp, input string tag);
    pix_col = 16'(c);
    pix_row = 16'(r);
`ifdef PADDLE_PIX_REG_EN
    @(posedge clk); #1;
`else
    #1;
`endif
    chk(tag, int'(paddle_pix), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_launch = 1'b0;
    pix_col = '0; pix_row = '0;
    repeat (3) @(negedge clk);

    // reset values
    push_exp("rst", 300, 399, 0, 0, 0);
    pop_chk();
    chk("rst_cnt", int'(dut.u_timer.count), 0);
    pix_probe(0, 0, 0, "rst_pix");
    @(negedge clk); rst_n = 1'b1;

    // idle frames in WAIT, sprite coverage edges
    ticks(3);
    push_exp("idle3", 300, 399, 0, 0, 0);
    pop_chk();
    pix_probe(300, 399, 1, "pix_tl");
    pix_probe(308, 399, 0, "pix_right_out");
    pix_probe(307, 406, 1, "pix_br");
    pix_probe(300, 407, 0, "pix_below_out");
    pix_probe(299, 399, 0, "pix_left_out");

`ifdef PADDLE_PIX_REG_EN
    @(negedge clk);
    pix_col = 16'd0; pix_row = 16'd0;
    @(negedge clk);
    pix_col = 16'd303; pix_row = 16'd402;
    #1 chk("lag_before_edge", int'(paddle_pix), 0);
    @(posedge clk); #1 chk("lag_after_edge", int'(paddle_pix), 1);
`endif

    // launch, then right for 10 frames
    launch();
    push_exp("launch", 300, 399, 1, 0, 0);
    pop_chk();
    chk("launch_cnt", int'(dut.u_timer.count), 88);
    btn_right = 1'b1;
    push_exp("right10", 310, 399, 1, 0, 0);
    ticks(10);
    pop_chk();

    // both buttons cancel
    btn_left = 1'b1;
    push_exp("both5", 310, 399, 1, 0, 0);
    ticks(5);
    pop_chk();
    btn_left = 1'b0;

    // frame_tick on two consecutive cycles counts twice
    push_exp("b2b", 312, 399, 1, 0, 0);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk); frame_tick = 1'b0;
    pop_chk();
    btn_right = 1'b0;

    // RUN -> CLIMB -> score -> HOLD -> WAIT
    do_reset();
    launch();
    push_exp("run88", 300, 399, 2, 0, 0);
    ticks(88);
    pop_chk();
    push_exp("climb1", 300, 397, 2, 0, 0);
    ticks(1);
    pop_chk();
    push_exp("climb179", 300, 41, 2, 0, 0);
    ticks(178);
    pop_chk();
    push_exp("score", 300, 40, 3, 0, 1);
    ticks(1);
    pop_chk();
    chk("score_cnt", int'(dut.u_timer.count), 60);
    pix_probe(300, 40, 0, "hold_blank");
    @(negedge clk);
    chk("score_pulse_end", int'(scored), 0);
    push_exp("hold59", 300, 40, 3, 0, 0);
    ticks(59);
    pop_chk();
    push_exp("hold_exit", 300, 399, 0, 0, 0);
    ticks(1);
    pop_chk();

    // left from launch until the left bound
    do_reset();
    btn_left = 1'b1;
    launch();
    push_exp("left252", 48, 71, 2, 0, 0);
    ticks(252);
    pop_chk();
    push_exp("loss", 47, 69, 3, 1, 0);
    ticks(1);
    pop_chk();
    pix_probe(47, 69, 0, "loss_blank");
    @(negedge clk);
    chk("loss_pulse_end", int'(lost), 0);
    btn_left = 1'b0;

    // asynchronous reset in the middle of HOLD
    ticks(30);
    chk("midhold_state", int'(state), 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    push_exp("midhold_rst", 300, 399, 0, 0, 0);
    pop_chk();
    chk("midhold_cnt", int'(dut.u_timer.count), 0);
    @(negedge clk); rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
